packet_buffer_scheduler: RTL



---
 rtl/packet_buffer_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/packet_buffer_scheduler.sv
// Four 6-slot packet buffers (3-bit slots, head at slot 0) behind one valid/ready
// enqueue port, drained one packet per tick by occupancy with a starvation override.
module packet_buffer_scheduler #(
  parameter int TICK_DIV     = 150,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_buf,
  input  logic [1:0]  in_data,
  output logic [1:0]  disp,
  output logic [1:0]  disp_src,
  output logic        disp_valid,
  output logic [17:0] buf1_o,
  output logic [17:0] buf2_o,
  output logic [17:0] buf3_o,
  output logic [17:0] buf4_o,
  output logic [2:0]  occ1,
  output logic [2:0]  occ2,
  output logic [2:0]  occ3,
  output logic [2:0]  occ4
);

  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [2:0] DEPTH = 3'd6;

  logic [CNT_W-1:0] tick_cnt_reg;
  logic             mode_q_reg;
  logic [1:0]       disp_reg;
  logic [1:0]       disp_src_reg;
  logic             disp_valid_reg;

  logic [17:0]      buf_all    [4];
  logic [2:0]       occ_all    [4];
  logic [ST_W-1:0]  starve_all [4];

  logic       tick;
  logic       enq_fire;
  logic       deq_fire;
  logic       starve_hit;
  logic [1:0] starve_idx;
  logic [1:0] max_idx;
  logic [2:0] best_occ;
  logic [1:0] deq_idx;
  logic [1:0] head_data;

  assign tick     = (tick_cnt_reg == CNT_W'(TICK_DIV - 1));
  assign in_ready = ~flush & (occ_all[in_buf] != DEPTH);
  assign enq_fire = in_valid & in_ready;

  // Lowest-index non-empty buffer that has waited too long; scanned high to low
  // so the last hit is the lowest index.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (occ_all[i] != 3'd0 && starve_all[i] >= ST_W'(STARVE_LIMIT)) begin
        starve_hit = 1'b1;
        starve_idx = 2'(i);
      end
    end
  end

  // Max occupancy; reliability mode lets equal occupancies overwrite, so the
  // highest index wins ties, while latency mode keeps the first (lowest).
  always_comb begin
    best_occ = 3'd0;
    max_idx  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (occ_all[i] != 3'd0 &&
          (occ_all[i] > best_occ || (mode_q_reg && occ_all[i] == best_occ))) begin
        best_occ = occ_all[i];
        max_idx  = 2'(i);
      end
    end
  end

  assign deq_idx   = starve_hit ? starve_idx : max_idx;
  assign deq_fire  = tick & ~flush & (best_occ != 3'd0);
  assign head_data = buf_all[deq_idx][2:1];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_buf
      logic [17:0]     buf_reg;
      logic [17:0]     buf_next;
      logic [2:0]      occ_reg;
      logic [2:0]      occ_next;
      logic [2:0]      wr_slot;
      logic [ST_W-1:0] starve_reg;
      logic [ST_W-1:0] starve_next;
      logic            deq_here;
      logic            enq_here;

      assign deq_here = deq_fire & (deq_idx == 2'(gi));
      assign enq_here = enq_fire & (in_buf == 2'(gi));
      // A same-cycle dequeue shifts first, so the new packet lands one slot lower.
      assign wr_slot  = deq_here ? occ_reg - 3'd1 : occ_reg;

      always_comb begin
        buf_next = deq_here ? {3'b000, buf_reg[17:3]} : buf_reg;
        for (int s = 0; s < 6; s++) begin
          if (enq_here && wr_slot == 3'(s)) begin
            buf_next[3*s +: 3] = {in_data, 1'b1};
          end
        end
        occ_next = occ_reg + 3'(enq_here) - 3'(deq_here);
      end

      always_comb begin
        starve_next = starve_reg;
        if (deq_fire) begin
          if (deq_here || occ_reg == 3'd0) begin
            starve_next = '0;
          end else if (starve_reg < ST_W'(STARVE_LIMIT)) begin
            starve_next = starve_reg + ST_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          buf_reg    <= '0;
          occ_reg    <= '0;
          starve_reg <= '0;
        end else if (flush) begin
          buf_reg    <= '0;
          occ_reg    <= '0;
          starve_reg <= '0;
        end else begin
          buf_reg    <= buf_next;
          occ_reg    <= occ_next;
          starve_reg <= starve_next;
        end
      end

      assign buf_all[gi]    = buf_reg;
      assign occ_all[gi]    = occ_reg;
      assign starve_all[gi] = starve_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg   <= '0;
      mode_q_reg     <= 1'b0;
      disp_reg       <= 2'd0;
      disp_src_reg   <= 2'd0;
      disp_valid_reg <= 1'b0;
    end else begin
      tick_cnt_reg   <= tick ? '0 : tick_cnt_reg + CNT_W'(1);
      disp_valid_reg <= deq_fire;
      if (tick) begin
        mode_q_reg <= mode;
      end
      if (deq_fire) begin
        disp_reg     <= head_data;
        disp_src_reg <= deq_idx;
      end
    end
  end

  assign disp       = disp_reg;
  assign disp_src   = disp_src_reg;
  assign disp_valid = disp_valid_reg;
  assign buf1_o     = buf_all[0];
  assign buf2_o     = buf_all[1];
  assign buf3_o     = buf_all[2];
  assign buf4_o     = buf_all[3];
  assign occ1       = occ_all[0];
  assign occ2       = occ_all[1];
  assign occ3       = occ_all[2];
  assign occ4       = occ_all[3];

endmodule
